// File: rtl/pcf8563_time_collector.sv
// Polls a PCF8563 through pcf8563_if, gathers the seven time registers (02h..08h),
// and publishes a range-checked binary timestamp or an error pulse with a cause code.
module pcf8563_time_collector #(
  parameter int unsigned POLL_CYCLES    = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       start,
  input  logic [7:0] rdata,
  input  logic       done,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [4:0] day,
  output logic [2:0] wday,
  output logic [3:0] month,
  output logic [6:0] year,
  output logic       century,
  output logic       vl,
  output logic       time_valid,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned PW = $clog2(POLL_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ERR_BCD     = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, TRIG, COLLECT, DECODE} state_t;

  state_t        state_q;
  logic [PW-1:0] poll_cnt_q;
  logic [TW-1:0] to_cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    frame_q [7];

  logic       start_q, time_valid_q, err_q, century_q, vl_q;
  logic [1:0] err_code_q;
  logic [5:0] sec_q, min_q;
  logic [4:0] hour_q, day_q;
  logic [2:0] wday_q;
  logic [3:0] month_q;
  logic [6:0] year_q;

  function automatic logic [7:0] bcd2bin(input logic [3:0] tens, input logic [3:0] units);
    return ({4'd0, tens} * 8'd10) + {4'd0, units};
  endfunction

  // NOTE: the byte buffer carries no reset; it is only read in DECODE, after all
  // seven slots of the current frame have been overwritten.
  always_ff @(posedge clk) begin
    if (state_q == COLLECT && en && done) begin
      frame_q[idx_q] <= rdata;
    end
  end

  logic [7:0] sec_d, min_d, hour_d, day_d, month_d, year_d;
  logic [2:0] wday_d;
  logic       bcd_err, range_err;

  // NOTE: every always_comb output gets a default up front so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    sec_d   = bcd2bin({1'b0, frame_q[0][6:4]}, frame_q[0][3:0]);
    min_d   = bcd2bin({1'b0, frame_q[1][6:4]}, frame_q[1][3:0]);
    hour_d  = bcd2bin({2'b0, frame_q[2][5:4]}, frame_q[2][3:0]);
    day_d   = bcd2bin({2'b0, frame_q[3][5:4]}, frame_q[3][3:0]);
    wday_d  = frame_q[4][2:0];
    month_d = bcd2bin({3'b0, frame_q[5][4]},   frame_q[5][3:0]);
    year_d  = bcd2bin(frame_q[6][7:4],         frame_q[6][3:0]);

    // Only nibbles wide enough to hold 10..15 can carry an invalid BCD digit.
    bcd_err = (frame_q[0][3:0] > 4'd9) || (frame_q[1][3:0] > 4'd9) ||
              (frame_q[2][3:0] > 4'd9) || (frame_q[3][3:0] > 4'd9) ||
              (frame_q[5][3:0] > 4'd9) || (frame_q[6][7:4] > 4'd9) ||
              (frame_q[6][3:0] > 4'd9);

    range_err = (sec_d > 8'd59) || (min_d > 8'd59) || (hour_d > 8'd23) ||
                (day_d == 8'd0) || (day_d > 8'd31) || (wday_d > 3'd6) ||
                (month_d == 8'd0) || (month_d > 8'd12) || (year_d > 8'd99);
  end

  // NOTE: all state below updates with non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      poll_cnt_q   <= '0;
      to_cnt_q     <= '0;
      idx_q        <= '0;
      start_q      <= 1'b0;
      time_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
      sec_q        <= '0;
      min_q        <= '0;
      hour_q       <= '0;
      day_q        <= '0;
      wday_q       <= '0;
      month_q      <= '0;
      year_q       <= '0;
      century_q    <= 1'b0;
      vl_q         <= 1'b0;
    end else begin
      start_q      <= 1'b0;
      time_valid_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!en) begin
            poll_cnt_q <= '0;
          end else if (poll_cnt_q == PW'(POLL_CYCLES - 1)) begin
            poll_cnt_q <= '0;
            start_q    <= 1'b1;
            state_q    <= TRIG;
          end else begin
            poll_cnt_q <= poll_cnt_q + 1'b1;
          end
        end
        TRIG: begin
          to_cnt_q <= '0;
          idx_q    <= '0;
          state_q  <= en ? COLLECT : IDLE;
        end
        COLLECT: begin
          // A byte arriving on the expiry cycle wins over the timeout.
          if (!en) begin
            state_q <= IDLE;
          end else if (done) begin
            idx_q    <= idx_q + 3'd1;
            to_cnt_q <= '0;
            if (idx_q == 3'd6) state_q <= DECODE;
          end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        DECODE: begin
          if (bcd_err) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_BCD;
          end else if (range_err) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_RANGE;
          end else begin
            time_valid_q <= 1'b1;
            sec_q        <= sec_d[5:0];
            min_q        <= min_d[5:0];
            hour_q       <= hour_d[4:0];
            day_q        <= day_d[4:0];
            wday_q       <= wday_d;
            month_q      <= month_d[3:0];
            year_q       <= year_d[6:0];
            century_q    <= frame_q[5][7];
            vl_q         <= frame_q[0][7];
          end
          poll_cnt_q <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Control bits the device reports but this block deliberately discards.
  logic unused_bits;
  assign unused_bits = ^{frame_q[1][7], frame_q[2][7:6], frame_q[3][7:6],
                         frame_q[4][7:3], frame_q[5][6:5], sec_d[7:6], min_d[7:6],
                         hour_d[7:5], day_d[7:5], month_d[7:4], year_d[7]};

  assign start      = start_q;
  assign time_valid = time_valid_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign sec        = sec_q;
  assign min        = min_q;
  assign hour       = hour_q;
  assign day        = day_q;
  assign wday       = wday_q;
  assign month      = month_q;
  assign year       = year_q;
  assign century    = century_q;
  assign vl         = vl_q;

endmodule
